fifo_stream_out: RTL and testbench

Read-side adapter placed directly downstream of sync_fifo. It drives the FIFO's rd_en and captures its registered dout, which arrives one cycle after a read. It presents the data as a valid/ready stream with a 2-entry output buffer, so reads continue at one beat per cycle under continuous m_ready. A synchronous clear flushes it in step with the FIFO's sclr_n.

---
 rtl/fifo_stream_out.sv | 114 +++++++++++
 tb/tb_fifo_stream_out.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Read-side adapter for sync_fifo: issues credit-checked reads, captures the registered
// dout one cycle later into a head/skid pair and presents it as a valid/ready stream.
// Optional macro FIFO_OUT_LAST_EN adds a per-packet beat counter and the m_last output.
module fifo_stream_out #(
  parameter int DATA_WIDTH = 8,
  parameter int PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  aclr,
  input  logic                  sclr_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_OUT_LAST_EN
  ,
  output logic                  m_last
`endif
);

  logic [1:0]            r_occ;
  logic                  r_in_flight;
  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_skid;

  logic                  w_pop;
  logic [2:0]            w_pending;
  logic [1:0]            w_occ_next;
  logic [DATA_WIDTH-1:0] w_head_next;
  logic [DATA_WIDTH-1:0] w_skid_next;

  assign w_pop   = m_valid && m_ready;
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_head;

  // Entries that will be held once this cycle's pop and in-flight capture settle;
  // a new read is only allowed if it still fits in the two-entry buffer.
  assign w_pending  = {1'b0, r_occ} + {2'b00, r_in_flight} - {2'b00, w_pop};
  assign fifo_rd_en = !aclr && sclr_n && !fifo_empty && (w_pending < 3'd2);

  always_comb begin
    w_occ_next  = r_occ;
    w_head_next = r_head;
    w_skid_next = r_skid;
    unique case ({w_pop, r_in_flight})
      2'b11: begin
        if (r_occ == 2'd2) begin
          w_head_next = r_skid;
          w_skid_next = fifo_dout;
        end else begin
          w_head_next = fifo_dout;
        end
      end
      2'b10: begin
        if (r_occ == 2'd2) begin
          w_head_next = r_skid;
        end
        w_occ_next = r_occ - 2'd1;
      end
      2'b01: begin
        if (r_occ == 2'd0) begin
          w_head_next = fifo_dout;
        end else begin
          w_skid_next = fifo_dout;
        end
        w_occ_next = r_occ + 2'd1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_occ       <= 2'd0;
      r_in_flight <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else if (!sclr_n) begin
      r_occ       <= 2'd0;
      r_in_flight <= 1'b0;
      r_head      <= '0;
      r_skid      <= '0;
    end else begin
      r_occ       <= w_occ_next;
      r_in_flight <= fifo_rd_en;
      r_head      <= w_head_next;
      r_skid      <= w_skid_next;
    end
  end

`ifdef FIFO_OUT_LAST_EN
  localparam int CW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_cnt_last;

  assign w_cnt_last = (r_cnt == CW'(PKT_LEN - 1));
  assign m_last     = m_valid && w_cnt_last;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      r_cnt <= '0;
    end else if (!sclr_n) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      r_cnt <= w_cnt_last ? '0 : r_cnt + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_out.sv
// Randomised and directed bench for fifo_stream_out: a queue-based FIFO model feeds the
// DUT, a scoreboard queue tracks beats read but not yet delivered, and a monitor checks them.
module tb_fifo_stream_out;
  localparam int DW = 8;
  localparam int PL = 4;

  logic          clk = 1'b0;
  logic          aclr = 1'b1;
  logic          sclr_n = 1'b1;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FIFO_OUT_LAST_EN
  logic          m_last;
`endif

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int dcount = 0;
  int lasts = 0;

  logic [7:0] fq[$];
  logic [7:0] wr_pend[$];
  logic [7:0] exp_q[$];

  fifo_stream_out #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .sclr_n    (sclr_n),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_OUT_LAST_EN
    ,
    .m_last    (m_last)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Behavioural FIFO: registered dout, writes visible one cycle after they are issued.
  always @(posedge clk) begin
    if (!sclr_n) begin
      fq.delete();
      wr_pend.delete();
      exp_q.delete();
    end else begin
      if (aclr) begin
        exp_q.delete();
      end else if (fifo_rd_en) begin
        chk(fq.size() != 0, "rd_en_while_empty", fq.size(), 1);
        if (fq.size() != 0) begin
          fifo_dout <= fq[0];
          exp_q.push_back(fq.pop_front());
          chk(exp_q.size() <= 3, "outstanding_bound", exp_q.size(), 3);
        end
      end
      while (wr_pend.size() != 0) fq.push_back(wr_pend.pop_front());
    end
    fifo_empty <= (fq.size() == 0);
  end

  // Monitor: a beat is taken at the edge following a negedge with m_valid && m_ready.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [7:0] e;
  always @(negedge clk) begin
    if (aclr || !sclr_n) begin
      prev_stall = 1'b0;
      dcount = 0;
    end else begin
      if (prev_stall) chk(m_valid && m_data == prev_data, "stall_hold", int'(m_data), int'(prev_data));
`ifdef FIFO_OUT_LAST_EN
      chk(m_last == (m_valid && dcount == PL - 1), "m_last", int'(m_last), int'(m_valid && dcount == PL - 1));
`endif
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_beat", int'(m_data), -1);
        end else begin
          e = exp_q.pop_front();
          chk(m_data == e, "beat_data", int'(m_data), int'(e));
        end
        $display("beat %0d data=0x%02h idx_in_pkt=%0d", delivered, m_data, dcount);
        delivered++;
        if (dcount == PL - 1) begin
          lasts++;
          dcount = 0;
        end else begin
          dcount++;
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_pend.push_back(d);
  endtask

  task automatic drain(input string name);
    int n = 0;
    m_ready = 1'b1;
    while ((fq.size() != 0 || wr_pend.size() != 0 || exp_q.size() != 0 || m_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 300, name, n, 300);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd_vec;
    logic [7:0] vld_vec;
    int d0;
    int rds;

    // Reset values
    @(negedge clk);
    chk(m_valid == 1'b0, "reset_valid", int'(m_valid), 0);
    chk(m_data == '0, "reset_data", int'(m_data), 0);
    chk(fifo_rd_en == 1'b0, "reset_rd_en", int'(fifo_rd_en), 0);
    @(posedge clk); #1;
    aclr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: latency and back-to-back delivery
    m_ready = 1'b1;
    d0 = delivered;
    wr(8'h11); wr(8'h22); wr(8'h33);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_vec[i]  = fifo_rd_en;
      vld_vec[i] = m_valid;
    end
    chk(rd_vec == 8'b0000_1110, "t1_rd_en_pattern", int'(rd_vec), 'h0e);
    chk(vld_vec == 8'b0011_1000, "t1_valid_pattern", int'(vld_vec), 'h38);
    chk(delivered - d0 == 3, "t1_count", delivered - d0, 3);
    @(posedge clk); #1;

    // 2: backpressure
    m_ready = 1'b0;
    d0 = delivered;
    rds = 0;
    for (int i = 0; i < 6; i++) wr(8'hA0 + 8'(i));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (fifo_rd_en) rds++;
    end
    chk(rds == 2, "t2_reads_during_stall", rds, 2);
    chk(m_valid && m_data == 8'hA0, "t2_head_held", int'(m_data), 'ha0);
    @(posedge clk); #1;
    drain("t2_drain");
    chk(delivered - d0 == 6, "t2_count", delivered - d0, 6);

    // 3: toggling ready
    d0 = delivered;
    for (int i = 0; i < 8; i++) wr(8'h01 + 8'(i));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    drain("t3_drain");
    chk(delivered - d0 == 8, "t3_count", delivered - d0, 8);

    // 4: synchronous clear with a buffered beat and one in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(8'hC0 + 8'(i));
    repeat (3) @(posedge clk);
    #1;
    sclr_n = 1'b0;
    @(posedge clk); #1;
    sclr_n = 1'b1;
    @(negedge clk);
    chk(m_valid == 1'b0, "t4_valid_after_sclr", int'(m_valid), 0);
    @(posedge clk); #1;
    d0 = delivered;
    wr(8'h5A);
    drain("t4_drain");
    chk(delivered - d0 == 1, "t4_count", delivered - d0, 1);

    // 5: asynchronous reset mid-stream; the buffered and in-flight beats are lost
    m_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 6; i++) wr(8'h70 + 8'(i));
    repeat (3) @(posedge clk);
    #2;
    chk(m_valid == 1'b1, "t5_valid_before_aclr", int'(m_valid), 1);
    #1;
    aclr = 1'b1;
    #1;
    chk(m_valid == 1'b0, "t5_aclr_valid", int'(m_valid), 0);
    chk(m_data == '0, "t5_aclr_data", int'(m_data), 0);
    chk(fifo_rd_en == 1'b0, "t5_aclr_rd_en", int'(fifo_rd_en), 0);
    @(posedge clk); #3;
    aclr = 1'b0;
    drain("t5_drain");
    chk(delivered - d0 == 4, "t5_count", delivered - d0, 4);

`ifdef FIFO_OUT_LAST_EN
    // 6: packet framing and its restart after a clear
    @(posedge clk); #1;
    sclr_n = 1'b0;
    @(posedge clk); #1;
    sclr_n = 1'b1;
    lasts = 0;
    for (int i = 0; i < 9; i++) wr(8'h90 + 8'(i));
    drain("t6_drain");
    chk(lasts == 2, "t6_last_count", lasts, 2);
    sclr_n = 1'b0;
    @(posedge clk); #1;
    sclr_n = 1'b1;
    for (int i = 0; i < 4; i++) wr(8'hE0 + 8'(i));
    drain("t6_drain2");
    chk(lasts == 3, "t6_last_after_clear", lasts, 3);
`endif

    // Random traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      m_ready = ($urandom_range(0, 3) != 0);
      sclr_n  = ($urandom_range(0, 99) != 0);
      if (sclr_n && $urandom_range(0, 2) != 0) wr(8'($urandom));
    end
    sclr_n = 1'b1;
    drain("rand_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
